// File: rtl/mean_frame_sink.sv
// mean_frame_sink: stores 7x7-mean pixels in a frame RAM, then replays the full frame in raster order with the border filled.
// Latency: first out_valid two cycles after the frame-completing write, then 1 pixel/cycle; optional MEAN_SINK_DROP_CNT_EN.
// Backpressure: out_ready stalls the readout (outputs held); inputs arriving during readout are dropped, never written.
module mean_frame_sink #(
    parameter int         IMAGE_WIDTH  = 320,
    parameter int         IMAGE_HEIGHT = 240,
    parameter int         BORDER       = 3,
    parameter int         LAST_COL     = IMAGE_WIDTH - 2,
    parameter logic [7:0] BORDER_VALUE = 8'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mean_valid,
    input  logic [7:0]  mean_out,
    input  logic [31:0] center_row_s1,
    input  logic [31:0] center_col_s1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_pixel,
    output logic        out_last,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int CW    = $clog2(IMAGE_WIDTH);
    localparam int RW    = $clog2(IMAGE_HEIGHT);
    localparam int AW    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT);
    localparam int DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT;

    localparam logic [CW-1:0] COL_MAX   = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(BORDER);
    localparam logic [CW-1:0] COL_LAST  = CW'(LAST_COL);
    localparam logic [RW-1:0] ROW_FIRST = RW'(BORDER);

    localparam logic [31:0] IN_ROW_LIM   = 32'(IMAGE_HEIGHT);
    localparam logic [31:0] IN_ROW_FINAL = 32'(IMAGE_HEIGHT - 1);
    localparam logic [31:0] IN_COL_FIRST = 32'(BORDER);
    localparam logic [31:0] IN_COL_LAST  = 32'(LAST_COL);

    typedef enum logic {COLLECT, READOUT} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rd_row;
    logic [CW-1:0]   rd_col;
    logic            rd_done;
    logic            s1_vld, s1_border, s1_last;
    logic [7:0]      ram_q;
    logic [7:0]      mem [DEPTH];

    logic            in_range, wr_en, frame_end;
    logic            issue, handshake, final_hs;
    logic [AW-1:0]   wr_addr, rd_addr;

    assign in_range  = (center_row_s1 < IN_ROW_LIM) &&
                       (center_col_s1 >= IN_COL_FIRST) && (center_col_s1 <= IN_COL_LAST);
    assign wr_en     = mean_valid && in_range && (state_q == COLLECT);
    assign frame_end = wr_en && (center_row_s1 == IN_ROW_FINAL) && (center_col_s1 == IN_COL_LAST);
    assign wr_addr   = AW'(center_row_s1[RW-1:0]) * AW'(IMAGE_WIDTH) + AW'(center_col_s1[CW-1:0]);
    assign rd_addr   = AW'(rd_row) * AW'(IMAGE_WIDTH) + AW'(rd_col);

    // s1 doubles as the prefetch slot: refill it whenever it is empty or being drained this cycle
    assign handshake = s1_vld && out_ready;
    assign final_hs  = handshake && s1_last;
    assign issue     = (state_q == READOUT) && !rd_done && (!s1_vld || out_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (frame_end) state_d = READOUT;
            READOUT: if (final_hs)  state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_row  <= '0;
            rd_col  <= '0;
            rd_done <= 1'b0;
        end else if (frame_end) begin
            rd_row  <= '0;
            rd_col  <= '0;
            rd_done <= 1'b0;
        end else if (issue) begin
            if (rd_col == COL_MAX) begin
                rd_col <= '0;
                if (rd_row == ROW_MAX) rd_done <= 1'b1;
                else                   rd_row  <= rd_row + 1'b1;
            end else begin
                rd_col <= rd_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_border <= 1'b0;
            s1_last   <= 1'b0;
        end else if (issue) begin
            s1_vld    <= 1'b1;
            s1_border <= (rd_row < ROW_FIRST) || (rd_col < COL_FIRST) || (rd_col > COL_LAST);
            s1_last   <= (rd_row == ROW_MAX) && (rd_col == COL_MAX);
        end else if (handshake) begin
            s1_vld    <= 1'b0;
        end
    end

    // Frame RAM is deliberately not reset; ram_q only advances on issue so a stalled pixel stays put
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= mean_out;
        if (issue) ram_q <= mem[rd_addr];
    end

    assign out_valid = s1_vld;
    assign out_last  = s1_vld && s1_last;
    assign out_pixel = !s1_vld ? 8'd0 : (s1_border ? BORDER_VALUE : ram_q);
    assign busy      = (state_q == READOUT);

`ifdef MEAN_SINK_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else if (mean_valid && (state_q == READOUT) && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_mean_frame_sink.sv
// tb_mean_frame_sink: directed scenarios against a frame-level reference model of mean_frame_sink (W=8, H=6).
// Latency: checks frame-start timing and gap-free readout; every handshake compared against the expected frame.
// Backpressure: pseudo-random out_ready with stall-stability checks on every held cycle.
module tb_mean_frame_sink;

    localparam int         W     = 8;
    localparam int         H     = 6;
    localparam int         BRD   = 3;
    localparam int         LASTC = 6;
    localparam logic [7:0] BV    = 8'hAA;
`ifdef MEAN_SINK_DROP_CNT_EN
    localparam logic [7:0] EXP_DROP = 8'd255;
`else
    localparam logic [7:0] EXP_DROP = 8'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mean_valid;
    logic [7:0]  mean_out;
    logic [31:0] center_row_s1;
    logic [31:0] center_col_s1;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pixel;
    logic        out_last;
    logic        busy;
    logic [7:0]  drop_cnt;

    mean_frame_sink #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .BORDER      (BRD),
        .LAST_COL    (LASTC),
        .BORDER_VALUE(BV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mean_valid   (mean_valid),
        .mean_out     (mean_out),
        .center_row_s1(center_row_s1),
        .center_col_s1(center_col_s1),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pixel    (out_pixel),
        .out_last     (out_last),
        .busy         (busy),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_mem [W*H];
    logic [7:0] exp_frame [W*H];
    logic [7:0] seen      [W*H];
    int         frames_started = 0;
    int         frames_done    = 0;
    int         pop_idx        = 0;
    logic       stall_prev     = 1'b0;
    logic [7:0] prev_pix       = 8'd0;
    logic       prev_last      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: a write lands only while no frame is pending readout; the final position snapshots the frame
    task automatic drive_px(input int r, input int c, input logic [7:0] v);
        mean_valid    = 1'b1;
        center_row_s1 = 32'(r);
        center_col_s1 = 32'(c);
        mean_out      = v;
        if (frames_started == frames_done && r >= 0 && r < H && c >= BRD && c <= LASTC) begin
            model_mem[r*W + c] = v;
            if (r == H-1 && c == LASTC) begin
                for (int i = 0; i < W*H; i++)
                    exp_frame[i] = (i / W < BRD || i % W < BRD || i % W > LASTC) ? BV : model_mem[i];
                frames_started++;
            end
        end
        tick();
        mean_valid = 1'b0;
    endtask

    task automatic feed_frame(input int add);
        for (int r = BRD; r < H; r++)
            for (int c = BRD; c <= LASTC; c++)
                drive_px(r, c, 8'(r*16 + c + add));
    endtask

    // Called one cycle after the frame-completing write
    task automatic expect_start(input string tag);
        check({tag, "_busy_n1"}, busy, 1);
        check({tag, "_valid_n1"}, out_valid, 0);
        tick();
        check({tag, "_valid_n2"}, out_valid, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (frames_started != frames_done && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, frames_done, frames_started);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            pop_idx    = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_pixel", out_pixel, prev_pix);
                check("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (frames_started == frames_done) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: pixel %0h last %0b with no frame pending", out_pixel, out_last);
                end else begin
                    check($sformatf("pixel[%0d]", pop_idx), out_pixel, exp_frame[pop_idx]);
                    check($sformatf("last[%0d]", pop_idx), out_last, pop_idx == W*H-1);
                    seen[pop_idx] = out_pixel;
                    if (pop_idx == W*H-1) begin
                        pop_idx = 0;
                        frames_done++;
                    end else begin
                        pop_idx++;
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_pix   = out_pixel;
            prev_last  = out_last;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lf;
        int         n;
        for (int i = 0; i < W*H; i++) model_mem[i] = 8'd0;
        rst_n = 1'b0; mean_valid = 1'b0; mean_out = 8'd0;
        center_row_s1 = '0; center_col_s1 = '0; out_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", out_valid, 0);
        check("rst_pixel", out_pixel, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Out-of-range coordinates, including near-misses of the final position
        drive_px(9, 2, 8'h11);
        drive_px(1, 7, 8'h22);
        drive_px(5, 7, 8'h33);
        drive_px(6, 6, 8'h44);
        drive_px(5, 2, 8'h55);
        tick();
        check("oor_busy", busy, 0);
        check("oor_valid", out_valid, 0);

        // Frame capture with continuous ready: exactly 48 back-to-back handshakes
        out_ready = 1'b1;
        feed_frame(0);
        expect_start("f1");
        repeat (W*H) tick();
        check("f1_gapfree_done", frames_done, frames_started);
        check("f1_busy_end", busy, 0);
        check("f1_valid_end", out_valid, 0);
        check("f1_px_4_5", seen[37], 8'h45);
        check("f1_px_0_0", seen[0], 8'hAA);
        check("f1_px_2_4", seen[20], 8'hAA);
        check("f1_px_3_7", seen[31], 8'hAA);
        check("f1_px_5_6", seen[46], 8'h56);

        // Backpressure
        out_ready = 1'b0;
        feed_frame(8'h80);
        lf = 8'h5A;
        n = 0;
        while (frames_started != frames_done && n < 600) begin
            lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
            out_ready = lf[0];
            tick();
            n++;
        end
        check("bp_drained", frames_done, frames_started);
        check("bp_px_4_4", seen[36], 8'hC4);
        check("bp_px_5_7", seen[47], 8'hAA);

        // Drops while stalled in readout
        out_ready = 1'b0;
        drive_px(5, 6, 8'h56);
        repeat (300) drive_px(4, 4, 8'hFF);
        check("drop_cnt", drop_cnt, EXP_DROP);
        out_ready = 1'b1;
        wait_idle("drop", 200);
        check("drop_px_4_4", seen[36], 8'hC4);
        check("drop_px_5_6", seen[46], 8'h56);

        // Back-to-back: write in final-handshake cycle dropped, next cycle starts a new frame
        out_ready = 1'b1;
        drive_px(5, 6, 8'h65);
        n = 0;
        while (!(out_valid && out_last) && n < 200) begin
            tick();
            n++;
        end
        check("b2b_final_seen", out_valid && out_last, 1);
        drive_px(4, 4, 8'h11);
        check("b2b_busy_fall", busy, 0);
        drive_px(5, 6, 8'h77);
        expect_start("b2b");
        wait_idle("b2b", 200);
        check("b2b_px_4_4", seen[36], 8'hC4);
        check("b2b_px_5_6", seen[46], 8'h77);

        // Async reset at readout index 20, then a full fresh frame
        out_ready = 1'b1;
        feed_frame(1);
        n = 0;
        while (pop_idx != 20 && n < 200) begin
            tick();
            n++;
        end
        check("rstmid_reached_20", pop_idx, 20);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", out_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_pixel", out_pixel, 0);
        check("rstmid_last", out_last, 0);
        frames_started = frames_done;
        repeat (2) tick();
        check("rstmid_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick();
        feed_frame(2);
        expect_start("f2");
        wait_idle("f2", 200);
        check("f2_px_4_5", seen[37], 8'h47);
        check("f2_px_3_3", seen[27], 8'h35);
        check("f2_px_2_4", seen[20], 8'hAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
